// File: rtl/loader_pkg.sv
// Shared state encoding and defaults for the instruction-memory boot loader.
package loader_pkg;

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid flags the 4th byte.
module word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt_reg;
  // Only the first three bytes need storage; the 4th is taken straight from byte_in.
  logic [23:0] shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_reg <= 2'd0;
      shift_reg    <= 24'd0;
    end else if (clear) begin
      byte_cnt_reg <= 2'd0;
      shift_reg    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      shift_reg    <= {byte_in, shift_reg[23:8]};
    end
  end

  assign word_valid = byte_valid && (byte_cnt_reg == 2'd3);
  assign word       = {byte_in, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing the instruction memory and gating the core reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH     = 256,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state_reg;
  logic [7:0]  len_lo_reg;
  logic [15:0] len_reg;
  logic [15:0] word_cnt_reg;
  logic [7:0]  csum_reg;

  logic        accept;
  logic        start_frame;
  logic        data_byte;
  logic [16:0] len_in;
  logic        word_valid;
  logic [31:0] word;

  assign accept    = rx_valid && rx_ready;
  assign data_byte = accept && (state_reg == ST_DATA);
  assign len_in    = {1'b0, rx_data, len_lo_reg};

  // A sync byte restarts a frame only from the idle-like states, never mid-frame.
  assign start_frame = accept && (rx_data == SYNC_BYTE) &&
                       ((state_reg == ST_SYNC) || (state_reg == ST_DONE) ||
                        (state_reg == ST_ERROR));

  word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_frame),
    .byte_valid (data_byte),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_SYNC;
      len_lo_reg   <= 8'd0;
      len_reg      <= 16'd0;
      word_cnt_reg <= 16'd0;
      csum_reg     <= 8'd0;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      cpu_reset_n  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (start_frame) begin
        state_reg    <= ST_LEN0;
        cpu_reset_n  <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
        csum_reg     <= 8'd0;
        word_cnt_reg <= 16'd0;
      end else if (accept) begin
        case (state_reg)
          ST_LEN0: begin
            len_lo_reg <= rx_data;
            state_reg  <= ST_LEN1;
          end
          ST_LEN1: begin
            len_reg <= len_in[15:0];
            if (len_in > DEPTH_W) begin
              state_reg <= ST_ERROR;
              error     <= 1'b1;
            end else if (len_in == 17'd0) begin
              state_reg <= ST_CSUM;
            end else begin
              state_reg <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum_reg <= csum_reg + rx_data;
            if (word_valid) begin
              mem_we       <= 1'b1;
              mem_addr     <= {14'd0, word_cnt_reg, 2'b00};
              mem_wdata    <= word;
              word_cnt_reg <= word_cnt_reg + 16'd1;
              if (word_cnt_reg == len_reg - 16'd1) begin
                state_reg <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (rx_data == csum_reg) begin
              state_reg   <= ST_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state_reg <= ST_ERROR;
              error     <= 1'b1;
            end
          end
          ST_SYNC, ST_DONE, ST_ERROR: begin
          end
          default: begin
            state_reg <= ST_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and immediate-assertion checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset_n;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[$];
  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  int          cycle = 0;
  int          last_wr_cycle = -100;
  int          last_gap = 0;
  int          wr_before = 0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always @(posedge clk) cycle = cycle + 1;

  // Write monitor: every strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      $display("write addr=%08h data=%08h cycle=%0d", mem_addr, mem_wdata, cycle);
      checks = checks + 1;
      assert (prev_we === 1'b0) else begin
        errors = errors + 1;
        $error("FAIL we_back_to_back observed=1 expected=0");
      end
      checks = checks + 1;
      assert (exp_q.size() > 0) else begin
        errors = errors + 1;
        $error("FAIL unexpected_write observed addr=%08h data=%08h expected none", mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks = checks + 1;
        assert (mem_addr === mon_e.addr && mem_wdata === mon_e.data) else begin
          errors = errors + 1;
          $error("FAIL write observed=%08h/%08h expected=%08h/%08h",
                 mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
      last_gap      = cycle - last_wr_cycle;
      last_wr_cycle = cycle;
      wr_count      = wr_count + 1;
    end
    prev_we = mem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the image in img; csum_adj corrupts the checksum, gaps inserts idle cycles.
  task automatic send_frame(input logic [7:0] csum_adj, input bit gaps);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] n;
    sum = 8'd0;
    n   = 16'(img.size());
    $display("frame words=%0d csum_adj=%0h gaps=%0d", n, csum_adj, gaps);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int k = 0; k < img.size(); k++) begin
      w = img[k];
      exp_q.push_back('{addr: 32'(k * 4), data: w});
      for (int j = 0; j < 4; j++) begin
        sum = sum + w[8*j +: 8];
        send_byte(w[8*j +: 8]);
        if (gaps) idle(1 + (j % 2));
      end
    end
    send_byte(sum + csum_adj);
  endtask

  task automatic check_result(input string tag, input logic d, input logic e,
                              input int writes);
    idle(3);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(d));
    chk({tag, "_writes"}, 32'(wr_count - wr_before), 32'(writes));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    $display("result %s done=%0d error=%0d cpu_reset_n=%0d", tag, done, error, cpu_reset_n);
    wr_before = wr_count;
  endtask

  initial begin
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    #11;
    reset_n = 1'b1;
    idle(2);
    chk("ready_after_reset", 32'(rx_ready), 32'd1);

    img = '{32'h00000013};
    send_frame(8'd0, 1'b0);
    check_result("single", 1'b1, 1'b0, 1);

    img = '{32'h04030201, 32'h08070605};
    send_frame(8'd0, 1'b0);
    chk("write_gap", 32'(last_gap), 32'd4);
    check_result("two_words", 1'b1, 1'b0, 2);

    send_frame(8'd1, 1'b0);
    check_result("bad_csum", 1'b0, 1'b1, 2);
    img = '{32'hCAFEF00D};
    send_frame(8'd0, 1'b0);
    check_result("after_error", 1'b1, 1'b0, 1);

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    check_result("len_overflow", 1'b0, 1'b1, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_result("len_zero", 1'b1, 1'b0, 0);

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    idle(1);
    img = '{32'h04030201, 32'h08070605};
    send_frame(8'd0, 1'b1);
    check_result("junk_gaps", 1'b1, 1'b0, 2);

    // Mid-frame reset: only the first word gets written before reset hits.
    exp_q.push_back('{addr: 32'd0, data: 32'h04030201});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    reset_n = 1'b0;
    #1;
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    wr_before = wr_count;
    #3;
    reset_n = 1'b1;
    idle(2);
    img = '{32'hDEADBEEF};
    send_frame(8'd0, 1'b0);
    check_result("after_reset", 1'b1, 1'b0, 1);
    chk("ready_end", 32'(rx_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
